// File: rtl/sysio_axi_mst_pkg.sv
// ============================================================================
// Module  : sysio_axi_mst_pkg
// Purpose : Shared bus widths and FSM state encoding for the sysio AXI4-Lite
//           master bridge.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sysio_axi_mst_pkg;

  // Core-side memory bus widths (address and data).
  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_BUS      = 32;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    SYSIO_MST_IDLE = 2'd0,
    SYSIO_MST_WR   = 2'd1,
    SYSIO_MST_RA   = 2'd2,
    SYSIO_MST_RD   = 2'd3
  } sysio_mst_state_e;

endpackage

`default_nettype wire

// File: rtl/sysio_axi_mst.sv
// ============================================================================
// Module  : sysio_axi_mst
// Purpose : AXI4-Lite master bridge from a single-outstanding core request
//           port to the sysio AW/W/AR/R channels. There is no B channel: a
//           write is complete once both the AW and W handshakes are done.
// Macro   : SYSIO_MST_TIMEOUT_EN - when defined, a transaction stalled for
//           TIMEOUT_CYC-1 cycles is aborted and mst_err_o pulses.
// Ports   : clk, rst              - clock, asynchronous active-high reset
//           mst_req_i/we/addr/... - core request (held until mst_ready_o)
//           mst_ready_o           - request accepted this cycle (IDLE only)
//           mst_wdone_o           - one-cycle write-complete pulse
//           mst_rvalid_o/rdata_o  - one-cycle read-valid pulse and read data
//           mst_err_o             - one-cycle timeout-abort pulse
//           m_axi_*               - AXI4-Lite AW, W, AR and R channels
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sysio_axi_mst
  import sysio_axi_mst_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_BUS,
  parameter int DATA_W      = MEM_BUS,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  // Core request port
  input  logic                mst_req_i,
  input  logic                mst_we_i,
  input  logic [ADDR_W-1:0]   mst_addr_i,
  input  logic [DATA_W-1:0]   mst_wdata_i,
  input  logic [DATA_W/8-1:0] mst_wstrb_i,
  output logic                mst_ready_o,
  output logic                mst_wdone_o,
  output logic                mst_rvalid_o,
  output logic [DATA_W-1:0]   mst_rdata_o,
  output logic                mst_err_o,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  // Elaboration-time parameter checks.
  generate
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("sysio_axi_mst: DATA_W must be a multiple of 8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("sysio_axi_mst: TIMEOUT_CYC must be at least 2");
    end
  endgenerate

  sysio_mst_state_e    state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                wdone_q;
  logic                rvalid_q;
  logic                err_q;

  // A channel counts as done if it completed earlier or handshakes now;
  // this lets AW and W finish in the same cycle or in any order.
  logic aw_ok;
  logic w_ok;
  logic wr_done;
  assign aw_ok   = aw_done_q | (awvalid_q & m_axi_awready);
  assign w_ok    = w_done_q  | (wvalid_q  & m_axi_wready);
  assign wr_done = aw_ok & w_ok;

  logic tmo_hit;

`ifdef SYSIO_MST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The abort fires on the edge where the count would reach TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Held at zero in IDLE, so it is zero on the first busy cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SYSIO_MST_IDLE) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q != SYSIO_MST_IDLE) && (tmo_cnt_q == C_TO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYSIO_MST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wdone_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Completion/abort indications are single-cycle pulses.
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        SYSIO_MST_IDLE: begin
          if (mst_req_i) begin
            addr_q  <= mst_addr_i;
            wdata_q <= mst_wdata_i;
            wstrb_q <= mst_wstrb_i;
            if (mst_we_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= SYSIO_MST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= SYSIO_MST_RA;
            end
          end
        end

        SYSIO_MST_WR: begin
          if (wr_done || tmo_hit) begin
            // Completion wins over a simultaneous timeout.
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdone_q   <= 1'b1;
            err_q     <= ~wr_done;
            state_q   <= SYSIO_MST_IDLE;
          end else begin
            if (awvalid_q && m_axi_awready) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (wvalid_q && m_axi_wready) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
          end
        end

        SYSIO_MST_RA: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= SYSIO_MST_RD;
          end else if (tmo_hit) begin
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= SYSIO_MST_IDLE;
          end
        end

        SYSIO_MST_RD: begin
          if (m_axi_rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= m_axi_rdata;
            rvalid_q <= 1'b1;
            state_q  <= SYSIO_MST_IDLE;
          end else if (tmo_hit) begin
            rready_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            state_q  <= SYSIO_MST_IDLE;
          end
        end

        default: begin
          state_q <= SYSIO_MST_IDLE;
        end
      endcase
    end
  end

  assign mst_ready_o   = (state_q == SYSIO_MST_IDLE);
  assign mst_wdone_o   = wdone_q;
  assign mst_rvalid_o  = rvalid_q;
  assign mst_rdata_o   = rdata_q;
  assign mst_err_o     = err_q;

  // One latched address serves both AW and AR; only one valid is ever high.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_sysio_axi_mst.sv
// ============================================================================
// Module  : tb_sysio_axi_mst
// Purpose : Self-checking bench for sysio_axi_mst. A transaction-level model
//           tracks which AXI obligations are outstanding and is compared with
//           the DUT every cycle; directed tests add literal latency/data pins.
//           Honours SYSIO_MST_TIMEOUT_EN (runs with TIMEOUT_CYC = 16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sysio_axi_mst;

`ifdef SYSIO_MST_TIMEOUT_EN
  localparam int TO     = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TO     = 256;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mst_req_i = 1'b0;
  logic        mst_we_i = 1'b0;
  logic [31:0] mst_addr_i = '0;
  logic [31:0] mst_wdata_i = '0;
  logic [3:0]  mst_wstrb_i = '0;
  logic        mst_ready_o, mst_wdone_o, mst_rvalid_o, mst_err_o;
  logic [31:0] mst_rdata_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [31:0] m_axi_rdata = '0;

  always #5 clk = ~clk;

  sysio_axi_mst #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .mst_req_i(mst_req_i), .mst_we_i(mst_we_i), .mst_addr_i(mst_addr_i),
    .mst_wdata_i(mst_wdata_i), .mst_wstrb_i(mst_wstrb_i),
    .mst_ready_o(mst_ready_o), .mst_wdone_o(mst_wdone_o),
    .mst_rvalid_o(mst_rvalid_o), .mst_rdata_o(mst_rdata_o), .mst_err_o(mst_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave: per-channel ready/rvalid delays ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int          aw_seen = 0, w_seen = 0, ar_seen = 0, r_seen = 0;
  logic [31:0] s_rdata = '0;

  always @(negedge clk) begin
    aw_seen       = m_axi_awvalid ? aw_seen + 1 : 0;
    w_seen        = m_axi_wvalid  ? w_seen  + 1 : 0;
    ar_seen       = m_axi_arvalid ? ar_seen + 1 : 0;
    r_seen        = m_axi_rready  ? r_seen  + 1 : 0;
    m_axi_awready = m_axi_awvalid && (aw_seen > aw_dly);
    m_axi_wready  = m_axi_wvalid  && (w_seen  > w_dly);
    m_axi_arready = m_axi_arvalid && (ar_seen > ar_dly);
    m_axi_rvalid  = m_axi_rready  && (r_seen  > r_dly);
    m_axi_rdata   = m_axi_rvalid ? s_rdata : 32'hDEAD_BEEF;
  end

  // ---------------- transaction-level expectation model ----------------
  // e_aw/e_w/e_ar/e_r: which AXI obligations are still outstanding.
  bit          e_busy, e_wr, e_aw, e_w, e_ar, e_r, e_wdone, e_rvalid, e_err, e_fin;
  int          e_age;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_busy = 0; e_wr = 0; e_aw = 0; e_w = 0; e_ar = 0; e_r = 0;
      e_wdone = 0; e_rvalid = 0; e_err = 0; e_age = 0; e_rdata = '0;
    end else begin
      e_wdone = 0; e_rvalid = 0; e_err = 0;
      if (!e_busy) begin
        if (mst_req_i) begin
          e_busy = 1; e_wr = mst_we_i; e_age = 0;
          e_addr = mst_addr_i; e_wdata = mst_wdata_i; e_wstrb = mst_wstrb_i;
          e_aw = mst_we_i; e_w = mst_we_i; e_ar = !mst_we_i;
        end
      end else begin
        e_age++;
        e_fin = 0;
        if (e_wr) begin
          if (e_aw && m_axi_awready) e_aw = 0;
          if (e_w && m_axi_wready)   e_w  = 0;
          e_fin = !e_aw && !e_w;
          if (e_fin) e_wdone = 1;
        end else if (e_ar) begin
          if (m_axi_arready) begin e_ar = 0; e_r = 1; end
        end else if (m_axi_rvalid) begin
          e_r = 0; e_rdata = m_axi_rdata; e_rvalid = 1; e_fin = 1;
        end
        if (e_fin) begin
          e_busy = 0;
        end else if (TMO_EN && e_age == TO - 1) begin
          e_aw = 0; e_w = 0; e_ar = 0; e_r = 0; e_busy = 0; e_err = 1;
          if (e_wr) e_wdone = 1;
          else begin e_rvalid = 1; e_rdata = '0; end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready",   mst_ready_o,   !e_busy);
    chk("awvalid", m_axi_awvalid, e_aw);
    chk("wvalid",  m_axi_wvalid,  e_w);
    chk("arvalid", m_axi_arvalid, e_ar);
    chk("rready",  m_axi_rready,  e_r);
    chk("wdone",   mst_wdone_o,   e_wdone);
    chk("rvalid",  mst_rvalid_o,  e_rvalid);
    chk("err",     mst_err_o,     e_err);
    chk("rdata",   mst_rdata_o,   e_rdata);
    if (e_aw) chk("awaddr", m_axi_awaddr, e_addr);
    if (e_w) begin
      chk("wdata", m_axi_wdata, e_wdata);
      chk("wstrb", m_axi_wstrb, e_wstrb);
    end
    if (e_ar) chk("araddr", m_axi_araddr, e_addr);
  end

  // Pulse bookkeeping for the directed tests.
  int n_wdone = 0, n_rvalid = 0, n_err = 0;
  int last_wdone = -1, last_rvalid = -1, last_err = -1;

  always @(negedge clk) begin
    if (mst_wdone_o)  begin n_wdone++;  last_wdone  = cyc; end
    if (mst_rvalid_o) begin n_rvalid++; last_rvalid = cyc; end
    if (mst_err_o)    begin n_err++;    last_err    = cyc; end
  end

  // Present a request and wait (bounded) for the cycle in which it is taken.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit hold, output int acc);
    bit got = 0;
    mst_req_i = 1; mst_we_i = we; mst_addr_i = addr;
    mst_wdata_i = wdata; mst_wstrb_i = wstrb;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (mst_ready_o) begin acc = cyc; got = 1; break; end
      @(negedge clk); #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no mst_ready_o, expected accept within 50 cycles");
    end
    @(posedge clk); #1;
    if (!hold) mst_req_i = 0;
  endtask

  // Wait (bounded) for mst_wdone_o (kind 0) or mst_rvalid_o (kind 1).
  task automatic wait_pulse(input int kind, output int at);
    bit got = 0;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if ((kind == 0) ? mst_wdone_o : mst_rvalid_o) begin at = cyc; got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL pulse_timeout: got no %s pulse, expected one within 60 cycles",
               (kind == 0) ? "wdone" : "rvalid");
    end
  endtask

  initial begin
    int a0, a1, t, nb;

    // Reset state.
    @(negedge clk); #1;
    chk("rst_ready",   mst_ready_o,   1);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rdata",   mst_rdata_o,   0);
    chk("rst_awaddr",  m_axi_awaddr,  0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: zero-wait write.
    issue(1, 32'h0000_0104, 32'hA5A5_1234, 4'hF, 0, a0);
    chk("w0_awvalid_T1", m_axi_awvalid, 1);
    chk("w0_wvalid_T1",  m_axi_wvalid,  1);
    chk("w0_awaddr",     m_axi_awaddr,  32'h0000_0104);
    chk("w0_wdata",      m_axi_wdata,   32'hA5A5_1234);
    chk("w0_wstrb",      m_axi_wstrb,   4'hF);
    wait_pulse(0, t);
    chk("w0_wdone_lat",  t - a0, 2);
    chk("w0_ready_T2",   mst_ready_o, 1);
    repeat (2) @(posedge clk); #1;

    // 2: AW ready at T1, W ready at T4.
    w_dly = 3; nb = n_wdone;
    issue(1, 32'h0000_0108, 32'h5A5A_0001, 4'h3, 0, a0);
    wait_pulse(0, t);
    chk("w1_wdone_lat", t - a0, 5);
    repeat (3) @(negedge clk); #1;
    chk("w1_wdone_cnt", n_wdone - nb, 1);
    w_dly = 0;
    @(posedge clk); #1;

    // 3: read with 3-cycle rvalid delay.
    r_dly = 3; s_rdata = 32'h0000_00FF;
    issue(0, 32'h0000_0200, 32'h0, 4'h0, 0, a0);
    wait_pulse(1, t);
    chk("r0_rvalid_lat", t - a0, 6);
    chk("r0_rdata",      mst_rdata_o, 32'h0000_00FF);
    repeat (3) @(negedge clk); #1;
    chk("r0_rdata_hold", mst_rdata_o, 32'h0000_00FF);
    r_dly = 0;
    @(posedge clk); #1;

    // 4: back-to-back write then read, request held high.
    s_rdata = 32'hCAFE_F00D;
    issue(1, 32'h0000_0100, 32'h1111_2222, 4'hC, 1, a0);
    issue(0, 32'h0000_0204, 32'h0, 4'h0, 0, a1);
    chk("b2b_accept_gap", a1 - a0, 2);
    chk("b2b_accept_at_wdone", a1, last_wdone);
    wait_pulse(1, t);
    chk("b2b_rvalid_lat", t - a1, 3);
    chk("b2b_rdata",      mst_rdata_o, 32'hCAFE_F00D);
    repeat (2) @(posedge clk); #1;

    // 5: reset while arvalid is high.
    ar_dly = 1000;
    issue(0, 32'h0000_0208, 32'h0, 4'h0, 0, a0);
    @(negedge clk);
    chk("mid_arvalid_pre", m_axi_arvalid, 1);
    nb = n_rvalid;
    #2 rst = 1;
    #1;
    chk("mid_arvalid_async", m_axi_arvalid, 0);
    chk("mid_rready_async",  m_axi_rready,  0);
    chk("mid_rvalid_async",  mst_rvalid_o,  0);
    chk("mid_err_async",     mst_err_o,     0);
    repeat (2) @(posedge clk);
    #1 rst = 0; ar_dly = 0;
    repeat (4) @(negedge clk); #1;
    chk("mid_ready_after", mst_ready_o, 1);
    chk("mid_no_rvalid",   n_rvalid - nb, 0);

`ifdef SYSIO_MST_TIMEOUT_EN
    // 6: slave never grants AR -> abort after 15 cycles in RA.
    ar_dly = 1000;
    @(posedge clk); #1;
    issue(0, 32'h0000_020C, 32'h0, 4'h0, 0, a0);
    wait_pulse(1, t);
    chk("tmo_lat",      t - a0, 16);
    chk("tmo_err",      mst_err_o, 1);
    chk("tmo_err_cyc",  last_err, t);
    chk("tmo_rdata",    mst_rdata_o, 0);
    chk("tmo_arvalid",  m_axi_arvalid, 0);
    chk("tmo_ready",    mst_ready_o, 1);
    ar_dly = 0;
    repeat (2) @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
